// File: rtl/alu_control_seq_pkg.sv
// Shared definitions for the registered ALU control block.
// Holds the ALU_Op class encodings, the ALU operation codes, the FSM state
// encoding and small helpers that classify an operation code as a MUL-class
// or DIV-class RV32M operation.
package alu_control_seq_pkg;

  localparam int unsigned CODE_W = 5;

  // ALU_Op classes produced by the main control unit
  localparam logic [2:0] ALUOP_R = 3'b000;
  localparam logic [2:0] ALUOP_I = 3'b001;
  localparam logic [2:0] ALUOP_U = 3'b010;
  localparam logic [2:0] ALUOP_B = 3'b100;
  localparam logic [2:0] ALUOP_J = 3'b101;

  // funct7 value that marks an R-class instruction as RV32M
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [CODE_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_OR     = 5'd2,
    OP_SLL    = 5'd3,
    OP_SRL    = 5'd4,
    OP_LUI    = 5'd5,
    OP_AND    = 5'd6,
    OP_XOR    = 5'd7,
    OP_BEQ    = 5'd8,
    OP_BNE    = 5'd9,
    OP_BLT    = 5'd10,
    OP_BGE    = 5'd11,
    OP_JAL    = 5'd12,
    OP_RSVD   = 5'd13,
    OP_MUL    = 5'd14,
    OP_MULH   = 5'd15,
    OP_MULHSU = 5'd16,
    OP_MULHU  = 5'd17,
    OP_DIV    = 5'd18,
    OP_DIVU   = 5'd19,
    OP_REM    = 5'd20,
    OP_REMU   = 5'd21
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // MUL class: codes 14..17, timed with MUL_LAT
  function automatic logic is_mul_code(input logic [CODE_W-1:0] c);
    return (c >= OP_MUL) && (c <= OP_MULHU);
  endfunction

  // DIV class: codes 18..21, timed with DIV_LAT
  function automatic logic is_div_code(input logic [CODE_W-1:0] c);
    return (c >= OP_DIV) && (c <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational ALU operation decoder.
// Ports:
//   funct7_i  - instruction[31:25]
//   alu_op_i  - instruction class from main control
//   funct3_i  - instruction[14:12]
//   code_o    - ALU operation code (unmatched selectors give ADD)
//   is_mul_o  - code is an RV32M multiply (MUL latency)
//   is_div_o  - code is an RV32M divide/remainder (DIV latency)
module alu_op_decode
  import alu_control_seq_pkg::*;
(
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        alu_op_i,
  input  logic [2:0]        funct3_i,
  output logic [CODE_W-1:0] code_o,
  output logic              is_mul_o,
  output logic              is_div_o
);

  alu_op_e code_s;

  // Class-then-funct3 decode; funct7 only matters for R class
  always_comb begin
    code_s = OP_ADD;
    case (alu_op_i)
      ALUOP_R: begin
        if (funct7_i == F7_MEXT) begin
          case (funct3_i)
            3'b000:  code_s = OP_MUL;
            3'b001:  code_s = OP_MULH;
            3'b010:  code_s = OP_MULHSU;
            3'b011:  code_s = OP_MULHU;
            3'b100:  code_s = OP_DIV;
            3'b101:  code_s = OP_DIVU;
            3'b110:  code_s = OP_REM;
            3'b111:  code_s = OP_REMU;
            default: code_s = OP_ADD;
          endcase
        end else begin
          case (funct3_i)
            3'b000:  code_s = funct7_i[5] ? OP_SUB : OP_ADD;
            3'b001:  code_s = OP_SLL;
            3'b100:  code_s = OP_XOR;
            3'b101:  code_s = OP_SRL;
            3'b110:  code_s = OP_OR;
            3'b111:  code_s = OP_AND;
            default: code_s = OP_ADD;
          endcase
        end
      end
      ALUOP_I: begin
        // ADDI, JALR, loads and stores all need an add
        case (funct3_i)
          3'b001:  code_s = OP_SLL;
          3'b100:  code_s = OP_XOR;
          3'b101:  code_s = OP_SRL;
          3'b110:  code_s = OP_OR;
          3'b111:  code_s = OP_AND;
          default: code_s = OP_ADD;
        endcase
      end
      ALUOP_U: code_s = OP_LUI;
      ALUOP_B: begin
        case (funct3_i)
          3'b000:  code_s = OP_BEQ;
          3'b001:  code_s = OP_BNE;
          3'b100:  code_s = OP_BLT;
          3'b101:  code_s = OP_BGE;
          default: code_s = OP_ADD;
        endcase
      end
      ALUOP_J: code_s = OP_JAL;
      default: code_s = OP_ADD;
    endcase
  end

  assign code_o   = code_s;
  assign is_mul_o = is_mul_code(code_s);
  assign is_div_o = is_div_code(code_s);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control for the ID/EX boundary of the RV32IM pipeline.
// Decodes {funct7, ALU_Op, funct3}, registers the operation code and
// sequences RV32M operations through a fixed-latency MUL/DIV unit.
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-low reset
//   valid_i           - decode-stage instruction valid
//   funct7_i/ALU_Op_i/funct3_i - decode selectors
//   stall_i           - downstream hold, freezes IDLE/DONE
//   flush_i           - kill in-flight operation
//   ALU_Operation_o   - registered operation code
//   valid_o           - ALU_Operation_o valid
//   mext_start_o      - one-cycle start pulse to the MUL/DIV unit
//   stall_o           - hold IF/ID while an M-op is running
module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned OP_W    = 5,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            valid_o,
  output logic            mext_start_o,
  output logic            stall_o
);

  // The counter is loaded with LAT-1 so RUN lasts exactly LAT cycles
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_q;
  logic              valid_q;
  logic              start_q;
  logic              stall_q;

  logic [CODE_W-1:0] dec_code_s;
  logic              dec_mul_s;
  logic              dec_div_s;
  logic [OP_W-1:0]   dec_op_s;
  logic [CNT_W-1:0]  lat_load_s;

  alu_op_decode u_decode (
    .funct7_i (funct7_i),
    .alu_op_i (ALU_Op_i),
    .funct3_i (funct3_i),
    .code_o   (dec_code_s),
    .is_mul_o (dec_mul_s),
    .is_div_o (dec_div_s)
  );

  assign dec_op_s   = OP_W'(dec_code_s);
  assign lat_load_s = dec_div_s ? DIV_LOAD : MUL_LOAD;

  // Control FSM, latency counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= {OP_W{1'b0}};
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stall_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new instruction exactly like IDLE (back-to-back issue)
        ST_IDLE, ST_DONE: begin
          if (stall_i) begin
            state_q <= state_q;
            valid_q <= valid_q;
          end else if (valid_i && (dec_mul_s || dec_div_s)) begin
            state_q <= ST_RUN;
            op_q    <= dec_op_s;
            cnt_q   <= lat_load_s;
            valid_q <= 1'b0;
            start_q <= 1'b1;
            stall_q <= 1'b1;
          end else if (valid_i) begin
            state_q <= ST_IDLE;
            op_q    <= dec_op_s;
            valid_q <= 1'b1;
            start_q <= 1'b0;
            stall_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            stall_q <= 1'b0;
          end
        end
        // Counter runs regardless of stall_i; upstream is held by stall_o
        ST_RUN: begin
          start_q <= 1'b0;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            stall_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          valid_q <= 1'b0;
          start_q <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign ALU_Operation_o = op_q;
  assign valid_o         = valid_q;
  assign mext_start_o    = start_q;
  assign stall_o         = stall_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed testbench for alu_control_seq with default parameters
// (MUL_LAT=2, DIV_LAT=32). Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_alu_control_seq;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] op;
    logic [2:0] f3;
    logic [4:0] code;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [6:0] funct7_i;
  logic [2:0] ALU_Op_i;
  logic [2:0] funct3_i;
  logic       stall_i;
  logic       flush_i;
  logic [4:0] ALU_Operation_o;
  logic       valid_o;
  logic       mext_start_o;
  logic       stall_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  int n_stall;
  int n_start;
  int n_valid;

  vec_t vecs [24] = '{
    '{7'b0100000, 3'b000, 3'b000, 5'd1},   // SUB
    '{7'b0000000, 3'b000, 3'b000, 5'd0},   // ADD
    '{7'b0000000, 3'b000, 3'b001, 5'd3},   // SLL
    '{7'b0000000, 3'b000, 3'b100, 5'd7},   // XOR
    '{7'b0000000, 3'b000, 3'b101, 5'd4},   // SRL
    '{7'b0000000, 3'b000, 3'b110, 5'd2},   // OR
    '{7'b0000000, 3'b000, 3'b111, 5'd6},   // AND
    '{7'b0000000, 3'b000, 3'b011, 5'd0},   // unmatched R
    '{7'b1111111, 3'b001, 3'b110, 5'd2},   // ORI, funct7 ignored
    '{7'b0000000, 3'b001, 3'b010, 5'd0},   // LW
    '{7'b1010101, 3'b001, 3'b001, 5'd3},   // SLLI
    '{7'b0100000, 3'b001, 3'b010, 5'd0},   // SW
    '{7'b0000000, 3'b010, 3'b111, 5'd5},   // LUI
    '{7'b0000000, 3'b100, 3'b101, 5'd11},  // BGE
    '{7'b0000000, 3'b100, 3'b000, 5'd8},   // BEQ
    '{7'b0000000, 3'b100, 3'b001, 5'd9},   // BNE
    '{7'b0000000, 3'b100, 3'b100, 5'd10},  // BLT
    '{7'b0000000, 3'b101, 3'b000, 5'd12},  // JAL
    '{7'b0000000, 3'b011, 3'b000, 5'd0},   // unused class
    '{7'b0100000, 3'b000, 3'b100, 5'd7},   // XOR with f5 set
    '{7'b1111111, 3'b001, 3'b100, 5'd7},   // XORI
    '{7'b0000000, 3'b100, 3'b010, 5'd0},   // unmatched B
    '{7'b1111111, 3'b001, 3'b111, 5'd6},   // ANDI
    '{7'b0000000, 3'b001, 3'b101, 5'd4}    // SRLI
  };

  always #5 clk = ~clk;

  alu_control_seq dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .funct7_i        (funct7_i),
    .ALU_Op_i        (ALU_Op_i),
    .funct3_i        (funct3_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .ALU_Operation_o (ALU_Operation_o),
    .valid_o         (valid_o),
    .mext_start_o    (mext_start_o),
    .stall_o         (stall_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
    valid_i  = 1'b1;
    funct7_i = f7;
    ALU_Op_i = op;
    funct3_i = f3;
  endtask

  // Counts stall_o cycles (the issue cycle is already counted) until it drops
  task automatic wait_stall_end();
    n_stall = 1;
    n_start = 0;
    for (int i = 0; i < 40 && stall_o; i++) begin
      step();
      if (stall_o) n_stall++;
      if (mext_start_o) n_start++;
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; funct7_i = 7'd0; ALU_Op_i = 3'd0; funct3_i = 3'd0;
    stall_i = 1'b0; flush_i = 1'b0;
    #2 reset = 1'b0;
    step(); step();
    check("rst_op",    ALU_Operation_o, 32'd0);
    check("rst_valid", valid_o,         32'd0);
    check("rst_start", mext_start_o,    32'd0);
    check("rst_stall", stall_o,         32'd0);
    reset = 1'b1;
    step();

    // Non-M decode, one vector per cycle back-to-back
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].f7, vecs[i].op, vecs[i].f3);
      step();
      check($sformatf("dec%0d_op", i), ALU_Operation_o, {27'd0, vecs[i].code});
      check($sformatf("dec%0d_valid", i), valid_o, 32'd1);
      check($sformatf("dec%0d_stall", i), stall_o, 32'd0);
    end
    valid_i = 1'b0;
    step();
    check("idle_valid", valid_o,         32'd0);
    check("idle_hold",  ALU_Operation_o, 32'd4);

    // stall_i holds IDLE outputs; flush beats stall
    drive(7'b0100000, 3'b000, 3'b000);
    step();
    valid_i = 1'b0; stall_i = 1'b1;
    step();
    check("hold_valid", valid_o,         32'd1);
    check("hold_op",    ALU_Operation_o, 32'd1);
    drive(7'b0000000, 3'b000, 3'b100);
    step();
    check("hold_nodec", ALU_Operation_o, 32'd1);
    flush_i = 1'b1;
    step();
    check("flush_stall_valid", valid_o, 32'd0);
    flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
    step();

    // DIV: one start pulse, 32 stall cycles, then code 18 valid
    drive(7'b0000001, 3'b000, 3'b100);
    step();
    valid_i = 1'b0;
    check("div_start", mext_start_o,    32'd1);
    check("div_stall", stall_o,         32'd1);
    check("div_valid0", valid_o,        32'd0);
    check("div_op",    ALU_Operation_o, 32'd18);
    wait_stall_end();
    check("div_stall_len", n_stall,      32'd32);
    check("div_start_once", n_start,     32'd0);
    check("div_done_valid", valid_o,     32'd1);
    check("div_done_op", ALU_Operation_o, 32'd18);
    step();
    check("div_idle_valid", valid_o, 32'd0);
    check("div_idle_stall", stall_o, 32'd0);

    // MUL followed by ADD presented during RUN (ignored) and issued in DONE
    drive(7'b0000001, 3'b000, 3'b000);
    step();
    check("mul_start", mext_start_o,    32'd1);
    check("mul_op",    ALU_Operation_o, 32'd14);
    drive(7'b0000000, 3'b000, 3'b000);
    step();
    check("mul_run_stall", stall_o,      32'd1);
    check("mul_run_start", mext_start_o, 32'd0);
    check("mul_run_op",    ALU_Operation_o, 32'd14);
    step();
    check("mul_done_valid", valid_o,     32'd1);
    check("mul_done_stall", stall_o,     32'd0);
    check("mul_done_op", ALU_Operation_o, 32'd14);
    step();
    check("b2b_add_op",    ALU_Operation_o, 32'd0);
    check("b2b_add_valid", valid_o,         32'd1);
    valid_i = 1'b0;
    step();
    check("b2b_idle_valid", valid_o, 32'd0);

    // Flush on cycle 5 of a DIV: nothing completes afterwards
    drive(7'b0000001, 3'b000, 3'b101);
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_flush_stall", stall_o, 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_stall", stall_o,      32'd0);
    check("flush_valid", valid_o,      32'd0);
    check("flush_start", mext_start_o, 32'd0);
    n_valid = 0;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o) n_valid++;
      if (stall_o) n_stall++;
    end
    check("flush_no_done",  n_valid, 32'd0);
    check("flush_no_stall", n_stall, 32'd0);

    // stall_i across DIV completion: DONE holds until stall_i falls
    drive(7'b0000001, 3'b000, 3'b100);
    step();
    valid_i = 1'b0; stall_i = 1'b1;
    wait_stall_end();
    check("sdiv_stall_len", n_stall, 32'd32);
    check("sdiv_valid", valid_o,     32'd1);
    drive(7'b0000000, 3'b000, 3'b110);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sdiv_hold%0d_valid", i), valid_o,         32'd1);
      check($sformatf("sdiv_hold%0d_op", i),    ALU_Operation_o, 32'd18);
    end
    valid_i = 1'b0; stall_i = 1'b0;
    step();
    check("sdiv_rel_valid", valid_o,         32'd0);
    check("sdiv_rel_op",    ALU_Operation_o, 32'd18);

    // Asynchronous reset in the middle of a DIV
    drive(7'b0000001, 3'b000, 3'b100);
    step();
    valid_i = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("mrst_op",    ALU_Operation_o, 32'd0);
    check("mrst_valid", valid_o,         32'd0);
    check("mrst_start", mext_start_o,    32'd0);
    check("mrst_stall", stall_o,         32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_valid", valid_o, 32'd0);
    check("post_rst_stall", stall_o, 32'd0);
    drive(7'b0000000, 3'b000, 3'b100);
    step();
    valid_i = 1'b0;
    check("post_rst_op",    ALU_Operation_o, 32'd7);
    check("post_rst_valid1", valid_o,        32'd1);
    check("post_rst_nostall", stall_o,       32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
